// File: rtl/controlador_vitais_if.sv
// Pet state / vitals bus between the state controller (master) and the
// vitals tracker (slave).
interface controlador_vitais_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       estado;
    logic [WIDTH-1:0] fome;
    logic [WIDTH-1:0] energia;
    logic             morreu;
    logic             alerta_fome;
    logic             alerta_sono;
    logic             tick;

    modport master (
        output estado,
        input  fome, energia, morreu, alerta_fome, alerta_sono, tick
    );

    modport slave (
        input  estado,
        output fome, energia, morreu, alerta_fome, alerta_sono, tick
    );
endinterface

// File: rtl/controlador_vitais.sv
// Hunger/energy meters for the pet, updated on a prescaled game tick from the
// one-hot state code; raises a sticky death flag and threshold alerts.
module controlador_vitais #(
    parameter int TICK_DIV    = 50000000,
    parameter int WIDTH       = 4,
    parameter int LIMIAR_FOME = 12,
    parameter int LIMIAR_SONO = 3
) (
    input  logic               clk,
    input  logic               rst,
    controlador_vitais_if.slave vit
);
    localparam int               CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam logic [WIDTH-1:0] LIM_F    = WIDTH'(LIMIAR_FOME);
    localparam logic [WIDTH-1:0] LIM_S    = WIDTH'(LIMIAR_SONO);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick_q, tick_evt;
    logic [WIDTH-1:0]  fome_q, fome_d, energia_q, energia_d;
    logic              morreu_q;
    logic signed [2:0] dfome, denergia;

    // Two extra bits: the top one flags underflow, the next one overflow.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] v,
                                                 input logic signed [2:0] d);
        logic [WIDTH+1:0] s;
        s = {2'b00, v} + {{(WIDTH-1){d[2]}}, d};
        if (s[WIDTH+1])  return '0;
        else if (s[WIDTH]) return MAX;
        else             return s[WIDTH-1:0];
    endfunction

    assign tick_evt = (cnt_q == CNT_LAST);
    assign cnt_d    = tick_evt ? '0 : cnt_q + 1'b1;

    always_comb begin
        dfome    = 3'sd0;
        denergia = 3'sd0;
        case (vit.estado)
            4'b0000: begin dfome =  3'sd1; denergia = -3'sd1; end
            4'b0001: begin dfome =  3'sd1; denergia =  3'sd2; end
            4'b0010: begin dfome = -3'sd2; denergia = -3'sd1; end
            4'b0100: begin dfome =  3'sd1; denergia = -3'sd2; end
            default: begin dfome =  3'sd0; denergia =  3'sd0; end
        endcase
        fome_d    = sat_add(fome_q, dfome);
        energia_d = sat_add(energia_q, denergia);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            fome_q    <= '0;
            energia_q <= MAX;
            morreu_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_evt;
            // Once dead the meters freeze; the prescaler keeps running.
            if (tick_evt && !morreu_q) begin
                fome_q    <= fome_d;
                energia_q <= energia_d;
                morreu_q  <= (fome_d == MAX) || (energia_d == '0);
            end
        end
    end

    assign vit.fome        = fome_q;
    assign vit.energia     = energia_q;
    assign vit.morreu      = morreu_q;
    assign vit.tick        = tick_q;
    assign vit.alerta_fome = (fome_q >= LIM_F);
    assign vit.alerta_sono = (energia_q <= LIM_S);
endmodule

// File: tb/tb_controlador_vitais.sv
// Bench for controlador_vitais: vector table, hand-written corner sequences and
// randomized states against a plain-integer pet model.
module tb_controlador_vitais;
    localparam int TD = 4, W = 4, MAXV = 15, LF = 12, LS = 3;
    localparam logic [3:0] IDLE = 4'b0000, DORM = 4'b0001, COM = 4'b0010,
                           AULA = 4'b0100, MORTO = 4'b1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    controlador_vitais_if #(.WIDTH(W)) vif();

    controlador_vitais #(
        .TICK_DIV(TD), .WIDTH(W), .LIMIAR_FOME(LF), .LIMIAR_SONO(LS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vit(vif)
    );

    int nvec = 0, nmis = 0;
    int mf, me, k;
    bit md, mt;

    typedef struct {
        bit         rs;
        logic [3:0] st;
        int         ticks;
        int         f, e;
        bit         m, af, asl;
    } row_t;
    row_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] got, input int exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > MAXV) ? MAXV : v;
    endfunction

    function automatic void deltas(input logic [3:0] st, output int df, output int de);
        df = 0; de = 0;
        if (st == IDLE)      begin df =  1; de = -1; end
        else if (st == DORM) begin df =  1; de =  2; end
        else if (st == COM)  begin df = -2; de = -1; end
        else if (st == AULA) begin df =  1; de = -2; end
    endfunction

    task automatic chk_model();
        chk("fome",        vif.fome,        mf);
        chk("energia",     vif.energia,     me);
        chk("morreu",      vif.morreu,      md);
        chk("tick",        vif.tick,        mt);
        chk("alerta_fome", vif.alerta_fome, mf >= LF);
        chk("alerta_sono", vif.alerta_sono, me <= LS);
    endtask

    // One clock; the model ticks on every TD-th edge since reset release.
    task automatic step(input logic [3:0] st);
        int df, de;
        vif.estado = st;
        @(posedge clk);
        #1;
        k++;
        mt = (k % TD == 0);
        if (mt && !md) begin
            deltas(st, df, de);
            mf = clamp(mf + df);
            me = clamp(me + de);
            md = (mf == MAXV) || (me == 0);
        end
        chk_model();
    endtask

    // Pulse reset between edges and check it acts without a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst fome",    vif.fome,        0);
        chk("rst energia", vif.energia,     MAXV);
        chk("rst morreu",  vif.morreu,      0);
        chk("rst tick",    vif.tick,        0);
        chk("rst alertas", {vif.alerta_fome, vif.alerta_sono}, 0);
        mf = 0; me = MAXV; md = 0; mt = 0; k = 0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] valid [4];
        int tc;
        valid = '{IDLE, DORM, COM, AULA};
        vif.estado = IDLE;

        tbl[0]  = '{1, IDLE,    4,  4, 11, 0, 0, 0};
        tbl[1]  = '{1, IDLE,    1,  1, 14, 0, 0, 0};
        tbl[2]  = '{0, COM,     1,  0, 13, 0, 0, 0};
        tbl[3]  = '{1, IDLE,    1,  1, 14, 0, 0, 0};
        tbl[4]  = '{0, DORM,    1,  2, 15, 0, 0, 0};
        tbl[5]  = '{0, DORM,    1,  3, 15, 0, 0, 0};
        tbl[6]  = '{1, IDLE,   11, 11,  4, 0, 0, 0};
        tbl[7]  = '{0, IDLE,    1, 12,  3, 0, 1, 1};
        tbl[8]  = '{0, 4'b0011, 3, 12,  3, 0, 1, 1};
        tbl[9]  = '{0, 4'b1111, 1, 12,  3, 0, 1, 1};
        tbl[10] = '{0, IDLE,    3, 15,  0, 1, 1, 1};
        tbl[11] = '{0, DORM,    5, 15,  0, 1, 1, 1};
        tbl[12] = '{1, AULA,    2,  2, 11, 0, 0, 0};
        tbl[13] = '{0, AULA,    5,  7,  1, 0, 0, 1};
        tbl[14] = '{0, AULA,    1,  8,  0, 1, 0, 1};
        tbl[15] = '{1, MORTO,   3,  0, 15, 0, 0, 0};
        tbl[16] = '{0, COM,     1,  0, 14, 0, 0, 0};

        #2;
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rs) do_reset();
            tc = 0;
            repeat (tbl[i].ticks * TD) begin
                step(tbl[i].st);
                tc += int'(vif.tick);
            end
            chk($sformatf("row%0d ticks",   i), tc,              tbl[i].ticks);
            chk($sformatf("row%0d fome",    i), vif.fome,        tbl[i].f);
            chk($sformatf("row%0d energia", i), vif.energia,     tbl[i].e);
            chk($sformatf("row%0d morreu",  i), vif.morreu,      tbl[i].m);
            chk($sformatf("row%0d a_fome",  i), vif.alerta_fome, tbl[i].af);
            chk($sformatf("row%0d a_sono",  i), vif.alerta_sono, tbl[i].asl);
        end

        // estado between ticks is ignored: COMENDO off-tick, IDLE on the tick edge.
        do_reset();
        repeat (4) begin
            repeat (TD - 1) step(COM);
            step(IDLE);
        end
        chk("offtick fome",    vif.fome,    4);
        chk("offtick energia", vif.energia, 11);

        // Reset mid-count at prescaler=2, then the next tick lands 4 edges later.
        do_reset();
        repeat (5 * TD) step(IDLE);
        chk("midrst pre fome", vif.fome, 5);
        repeat (2) step(IDLE);
        do_reset();
        for (int i = 0; i < TD; i++) begin
            step(IDLE);
            chk($sformatf("midrst tick%0d", i + 1), vif.tick, (i == TD - 1));
        end
        chk("midrst fome", vif.fome, 1);

        // Randomized states, including non-one-hot codes and sporadic resets.
        do_reset();
        repeat (1500) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) step(4'($urandom_range(0, 15)));
            else                           step(valid[$urandom_range(0, 3)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
